// File: rtl/roberto_rx_serial_if.sv
// Received-byte bus of the serial receiver: data byte plus one-cycle event strobes.
// The receiver drives it through the master modport; consumers read through slave.
interface roberto_rx_serial_if;
    logic [7:0] dados;
    logic       pronto;
    logic       erro_frame;
    logic       erro_paridade;

    modport master (
        output dados,
        output pronto,
        output erro_frame,
        output erro_paridade
    );

    modport slave (
        input dados,
        input pronto,
        input erro_frame,
        input erro_paridade
    );
endinterface

// File: rtl/roberto_rx_serial.sv
// UART receiver, 8N1 (8E1 when RX_PARITY_EN is defined), DIV = CLK_FREQ/BAUD clocks per bit.
// Latency: pronto 1 clock after the stop-bit sample (~9.5*DIV + 3 clocks from the start edge).
// No backpressure: every accepted byte is announced by a single-cycle pronto pulse.
module roberto_rx_serial #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       zera,
    input  logic                       RX,
    output logic [3:0]                 db_estado,
    roberto_rx_serial_if.master        rx_if
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TICK_BIT  = TW'(DIV - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(DIV / 2 - 1);

    typedef enum logic [3:0] {
        INICIAL  = 4'b0000,
        ESPERA   = 4'b0001,
        START    = 4'b0010,
        RECEBE   = 4'b0011,
        PARIDADE = 4'b0100,
        STOP     = 4'b0101,
        REGISTRA = 4'b0110,
        ERRO     = 4'b0111
    } estado_t;

    estado_t       estado_q, estado_d;
    logic          rx_meta_q, rx_sync_q;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    dados_q, dados_d;
    logic          ferr_q, ferr_d;
    logic          tick_end;
    logic          pronto;
`ifdef RX_PARITY_EN
    logic          par_err_q, par_err_d;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= INICIAL;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            dados_q   <= '0;
            ferr_q    <= 1'b0;
`ifdef RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            estado_q  <= estado_d;
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            dados_q   <= dados_d;
            ferr_q    <= ferr_d;
`ifdef RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    assign tick_end = (tick_q == TICK_BIT);

    always_comb begin
        estado_d = estado_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        dados_d  = dados_q;
        ferr_d   = 1'b0;
`ifdef RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        if (zera) begin
            estado_d = INICIAL;
        end else begin
            case (estado_q)
                INICIAL: begin
                    tick_d   = '0;
                    bit_d    = '0;
                    shift_d  = '0;
                    estado_d = ESPERA;
                end
                ESPERA: begin
                    if (!rx_sync_q) begin
                        tick_d   = '0;
                        estado_d = START;
                    end
                end
                START: begin
                    // Mid-start-bit recheck rejects glitches shorter than half a bit.
                    if (tick_q == TICK_HALF) begin
                        tick_d   = '0;
                        bit_d    = '0;
                        estado_d = rx_sync_q ? ESPERA : RECEBE;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                RECEBE: begin
                    if (tick_end) begin
                        tick_d  = '0;
                        shift_d = {rx_sync_q, shift_q[7:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
`ifdef RX_PARITY_EN
                            estado_d = PARIDADE;
`else
                            estado_d = STOP;
`endif
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
`ifdef RX_PARITY_EN
                PARIDADE: begin
                    if (tick_end) begin
                        tick_d    = '0;
                        par_err_d = (rx_sync_q != ^shift_q);
                        estado_d  = STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick_end) begin
                        tick_d = '0;
                        if (rx_sync_q) begin
                            estado_d = REGISTRA;
                        end else begin
                            estado_d = ERRO;
                            ferr_d   = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                REGISTRA: begin
                    dados_d  = shift_q;
                    estado_d = ESPERA;
                end
                ERRO: begin
                    // A held break must end before a new start edge can be accepted.
                    if (rx_sync_q) begin
                        estado_d = ESPERA;
                    end
                end
                default: estado_d = INICIAL;
            endcase
        end
    end

    // The new byte is forwarded in the pronto cycle itself so data and strobe align.
    assign pronto              = (estado_q == REGISTRA) && !zera;
    assign rx_if.pronto        = pronto;
    assign rx_if.dados         = pronto ? shift_q : dados_q;
    assign rx_if.erro_frame    = ferr_q && !zera;
`ifdef RX_PARITY_EN
    assign rx_if.erro_paridade = pronto && par_err_q;
`else
    assign rx_if.erro_paridade = 1'b0;
`endif
    assign db_estado           = estado_q;
endmodule

// File: tb/tb_roberto_rx_serial.sv
// Randomized bench for roberto_rx_serial at CLK_FREQ=1600, BAUD=100 (16 clocks per bit),
// comparing received events against a frame-level model of the serial protocol.
module tb_roberto_rx_serial;
    localparam int CLK_FREQ = 1600;
    localparam int BAUD     = 100;
    localparam int DIV      = CLK_FREQ / BAUD;
`ifdef RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int NBITS = PAR_EN ? 11 : 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       zera;
    logic       RX;
    logic [3:0] db_estado;

    roberto_rx_serial_if rx_bus ();

    roberto_rx_serial #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clock     (clock),
        .reset     (reset),
        .zera      (zera),
        .RX        (RX),
        .db_estado (db_estado),
        .rx_if     (rx_bus)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Event monitor
    int         cyc = 0;
    int         pronto_n = 0, ferr_n = 0, perr_n = 0;
    int         long_pulse_n = 0, perr_alone_n = 0;
    int         last_pronto_cyc = 0;
    logic [7:0] got_q[$];
    logic       prev_pronto = 1'b0, prev_ferr = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (rx_bus.pronto) begin
            pronto_n++;
            last_pronto_cyc = cyc;
            got_q.push_back(rx_bus.dados);
        end
        if (rx_bus.erro_frame) ferr_n++;
        if (rx_bus.erro_paridade) perr_n++;
        if (rx_bus.erro_paridade && !rx_bus.pronto) perr_alone_n++;
        if ((prev_pronto && rx_bus.pronto) || (prev_ferr && rx_bus.erro_frame)) long_pulse_n++;
        prev_pronto = rx_bus.pronto;
        prev_ferr   = rx_bus.erro_frame;
    end

    // Stimulus: every task leaves the bench 1 time unit after a rising edge.
    task automatic drive_bit(input logic b);
        RX = b;
        repeat (DIV) @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic stop_b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit((^d) ^ par_bad);
        drive_bit(stop_b);
    endtask

    int         p0, f0, e0, g0, start_cyc;
    int         exp_ferr, exp_perr;
    logic [7:0] exp_q[$];
    logic [7:0] last_good;

    initial begin
        reset = 1'b1;
        zera  = 1'b0;
        RX    = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_estado", db_estado, 4'b0000);
        chk("rst_dados", rx_bus.dados, 8'h00);
        chk("rst_pronto", rx_bus.pronto, 1'b0);
        chk("rst_ferr", rx_bus.erro_frame, 1'b0);
        chk("rst_perr", rx_bus.erro_paridade, 1'b0);
        reset = 1'b1;
        idle(3);
        chk("idle_espera", db_estado, 4'b0001);

        // Single byte plus start-edge-to-pronto latency
        p0 = pronto_n; f0 = ferr_n;
        start_cyc = cyc;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(DIV);
        chk("a5_pronto_cnt", pronto_n - p0, 1);
        chk("a5_dados", rx_bus.dados, 8'hA5);
        chk("a5_ferr_cnt", ferr_n - f0, 0);
        chk("a5_latency", last_pronto_cyc - start_cyc, (2 * NBITS - 1) * DIV / 2 + 3);

        // Back-to-back frames
        p0 = pronto_n; g0 = got_q.size();
        send_frame(8'h3C, 1'b0, 1'b1);
        send_frame(8'hC3, 1'b0, 1'b1);
        idle(DIV);
        chk("b2b_pronto_cnt", pronto_n - p0, 2);
        if (got_q.size() >= g0 + 2) begin
            chk("b2b_first", got_q[g0], 8'h3C);
            chk("b2b_second", got_q[g0+1], 8'hC3);
        end
        chk("b2b_dados", rx_bus.dados, 8'hC3);

        // Short low glitch
        p0 = pronto_n; f0 = ferr_n;
        RX = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        idle(2 * DIV);
        chk("glitch_pronto_cnt", pronto_n - p0, 0);
        chk("glitch_ferr_cnt", ferr_n - f0, 0);
        chk("glitch_estado", db_estado, 4'b0001);

        // Framing error followed by a held break
        p0 = pronto_n; f0 = ferr_n;
        send_frame(8'h55, 1'b0, 1'b0);
        drive_bit(1'b0);
        chk("break_estado", db_estado, 4'b0111);
        drive_bit(1'b0);
        drive_bit(1'b0);
        idle(2 * DIV);
        chk("ferr_cnt", ferr_n - f0, 1);
        chk("ferr_pronto_cnt", pronto_n - p0, 0);
        chk("ferr_dados_kept", rx_bus.dados, 8'hC3);
        chk("ferr_back_espera", db_estado, 4'b0001);

        // Synchronous clear mid-frame
        p0 = pronto_n;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        zera = 1'b1;
        @(posedge clock);
        #1;
        zera = 1'b0;
        chk("zera_inicial", db_estado, 4'b0000);
        idle(8 * DIV);
        chk("zera_pronto_cnt", pronto_n - p0, 0);
        chk("zera_dados_kept", rx_bus.dados, 8'hC3);
        chk("zera_espera", db_estado, 4'b0001);

        // Reset during bit 4 of 0xFF, then a fresh byte
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        RX = 1'b1;
        repeat (DIV / 2) @(posedge clock);
        #1;
        reset = 1'b0;
        #3;
        chk("midrst_estado", db_estado, 4'b0000);
        chk("midrst_dados", rx_bus.dados, 8'h00);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        idle(6 * DIV);
        p0 = pronto_n; g0 = got_q.size();
        send_frame(8'h12, 1'b0, 1'b1);
        idle(DIV);
        chk("midrst_pronto_cnt", pronto_n - p0, 1);
        if (got_q.size() > g0) chk("midrst_byte", got_q[g0], 8'h12);
        chk("midrst_dados_after", rx_bus.dados, 8'h12);

`ifdef RX_PARITY_EN
        // Parity mismatch: 0x07 has odd weight, so an even-parity bit of 0 is wrong
        p0 = pronto_n; e0 = perr_n;
        send_frame(8'h07, 1'b1, 1'b1);
        idle(DIV);
        chk("par_pronto_cnt", pronto_n - p0, 1);
        chk("par_perr_cnt", perr_n - e0, 1);
        chk("par_dados", rx_bus.dados, 8'h07);
`endif

        // Randomized frames against the frame-level model
        p0 = pronto_n; f0 = ferr_n; e0 = perr_n; g0 = got_q.size();
        exp_ferr = 0; exp_perr = 0;
        last_good = rx_bus.dados;
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            logic       stop_ok, par_bad;
            d       = 8'($urandom);
            stop_ok = ($urandom_range(0, 4) != 0);
            par_bad = ($urandom_range(0, 3) == 0);
            send_frame(d, par_bad, stop_ok);
            if (stop_ok) begin
                exp_q.push_back(d);
                last_good = d;
                if (PAR_EN && par_bad) exp_perr++;
            end else begin
                exp_ferr++;
            end
            chk("rnd_dados", rx_bus.dados, last_good);
            idle(stop_ok ? $urandom_range(0, 2 * DIV) : $urandom_range(1, 2 * DIV));
        end
        idle(2 * DIV);
        chk("rnd_pronto_cnt", pronto_n - p0, exp_q.size());
        chk("rnd_ferr_cnt", ferr_n - f0, exp_ferr);
        chk("rnd_perr_cnt", perr_n - e0, exp_perr);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (g0 + i < got_q.size()) chk("rnd_byte", got_q[g0+i], exp_q[i]);
        end

        chk("pulse_width", long_pulse_n, 0);
        chk("perr_without_pronto", perr_alone_n, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/roberto_rx_serial.md
ROBERTO_RX_SERIAL -- requirements
Module: roberto_rx_serial

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate.
REQ-003 SHALL derive DIV = CLK_FREQ/BAUD (integer division) as clocks per bit; DIV >= 4.
REQ-004 SHALL have port: clock  in  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port: reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port: zera  in  1  synchronous clear; aborts any frame and returns FSM to idle.
REQ-007 SHALL have port: RX  in  1  asynchronous serial line, idle high, LSB first.
REQ-008 SHALL have port: dados  out  8  last accepted byte, held until the next accepted byte.
REQ-009 SHALL have port: pronto  out  1  one-cycle pulse on each accepted byte (feeds controller pronto_recepcao).
REQ-010 SHALL have port: erro_frame  out  1  one-cycle pulse when stop bit samples 0.
REQ-011 SHALL have port: erro_paridade  out  1  one-cycle pulse on parity mismatch (constant 0 without macro).
REQ-012 SHALL have port: db_estado  out  4  current FSM state encoding.

Function
REQ-013 SHALL pass RX through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value.
REQ-014 SHALL implement states: inicial(0000), espera(0001), start(0010), recebe(0011), paridade(0100), stop(0101), registra(0110), erro(0111).
REQ-015 inicial -> espera unconditionally after one cycle; inicial clears bit counter, tick counter, shift register.
REQ-016 espera: on synchronized RX = 0, go to start and clear tick counter.
REQ-017 start: after DIV/2 clocks resample; if RX = 0 go to recebe, else (glitch) return to espera with no output pulse.
REQ-018 recebe: every DIV clocks sample RX, shift into bit 7 of shift register (LSB first); after 8th sample go to paridade (macro) or stop.
REQ-019 paridade: after DIV clocks sample parity bit, record mismatch flag vs even parity of 8 data bits; go to stop.
REQ-020 stop: after DIV clocks sample; RX = 1 -> registra; RX = 0 -> erro.
REQ-021 registra: load dados from shift register, pulse pronto for exactly one cycle (pulse erro_paridade simultaneously if mismatch), go to espera.
REQ-022 erro: pulse erro_frame for one cycle, dados unchanged, no pronto; go to espera only once RX = 1 (break held low does not retrigger).
REQ-023 Latency: pronto asserts 1 clock after the stop-bit sample, about 9.5*DIV (10.5*DIV with parity) + 3 clocks after the start edge at the RX pin.
REQ-024 zera SHALL take priority over every transition; on zera FSM goes to inicial, dados keeps its value, no pulses are emitted that cycle.
REQ-025 A start edge arriving in the registra cycle SHALL be detected in the following espera cycle; back-to-back frames are received without loss.
REQ-026 Unused state encodings SHALL go to inicial.
REQ-027 Tick counter width SHALL be ceil(log2(DIV)) bits; it never wraps mid-bit.

Reset
REQ-028 While reset = 0: FSM = inicial, dados = 0x00, pronto = erro_frame = erro_paridade = 0, synchronizer = 1, counters = 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial byte; after release the receiver waits for a fresh start edge.

Configuration
REQ-030 Macro RX_PARITY_EN SHALL, when defined, enable state paridade and frame format 8E1 (11 bits); when undefined, format is 8N1 (10 bits), paridade is unreachable and erro_paridade is tied 0.

Verification (bench: CLK_FREQ=1600, BAUD=100, DIV=16)
REQ-031 Send 0xA5 8N1 -> dados = 0xA5, exactly one pronto pulse, erro_frame stays 0.
REQ-032 Send 0x3C then 0xC3 with no idle gap -> two pronto pulses, dados 0x3C then 0xC3.
REQ-033 RX low for 4 clocks then high -> no pronto, FSM back in espera (0001).
REQ-034 Send 0x55 with stop bit forced 0 -> erro_frame one pulse, dados retains prior value, no pronto.
REQ-035 Assert reset (0) during bit 4 of 0xFF, release, send 0x12 -> only 0x12 reported.
REQ-036 With RX_PARITY_EN, send 0x07 with parity bit 0 -> pronto and erro_paridade pulse together, dados = 0x07.
